// File: rtl/i2s_tx.sv
// I2S transmitter: one-pair holding buffer, BCLK/LRCLK generation and
// MSB-first serial data with the standard one-BCLK delay after LRCLK.
module i2s_tx #(
    parameter int DATA_W   = 16,
    parameter int BCLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_right,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_bclk,
    output logic              o_lrclk,
    output logic              o_sdata,
    output logic              o_underrun
);

    localparam int FRAME = 2 * DATA_W;
    localparam int DIV_W = $clog2(BCLK_DIV);
    localparam int BIT_W = $clog2(FRAME);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BCLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);
    localparam logic [BIT_W-1:0] BIT_HALF = BIT_W'(DATA_W);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_nxt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [BIT_W-1:0]  bit_nxt;
    logic              tick;
    logic              frame_tick;
    logic              accept;
    logic              hold_full;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic [FRAME-1:0]  shreg;

    always_comb begin
        tick       = (div_cnt == DIV_LAST);
        frame_tick = tick && (bit_cnt == BIT_LAST);
        accept     = i_valid && !hold_full;
        div_nxt    = tick ? '0 : div_cnt + DIV_ONE;
        bit_nxt    = bit_cnt;
        if (tick) begin
            bit_nxt = frame_tick ? '0 : bit_cnt + BIT_ONE;
        end
    end

    assign o_ready = !hold_full;

    // Clocks are registered from the next counter values so they stay
    // aligned with the counters and glitch-free.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            o_bclk  <= 1'b0;
            o_lrclk <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            o_bclk  <= (div_nxt >= DIV_HALF);
            o_lrclk <= (bit_nxt >= BIT_HALF);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (frame_tick && hold_full) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_l    <= i_left;
            hold_r    <= i_right;
        end
    end

    // The top bit is emitted before the reload, so the previous frame's
    // right LSB lands in bit slot 0 of the new frame.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shreg      <= '0;
            o_sdata    <= 1'b0;
            o_underrun <= 1'b0;
        end else begin
            o_underrun <= frame_tick && !hold_full;
            if (tick) begin
                o_sdata <= shreg[FRAME-1];
                if (frame_tick) begin
                    shreg <= hold_full ? {hold_l, hold_r} : '0;
                end else begin
                    shreg <= {shreg[FRAME-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with default parameters (16-bit, div 4).
module tb_i2s_tx;

    logic        clk;
    logic        i_rst;
    logic [15:0] i_left;
    logic [15:0] i_right;
    logic        i_valid;
    logic        o_ready;
    logic        o_bclk;
    logic        o_lrclk;
    logic        o_sdata;
    logic        o_underrun;

    int checks;
    int errors;

    logic [15:0] frame_l [12];
    logic [15:0] frame_r [12];

    i2s_tx #(.DATA_W(16), .BCLK_DIV(4)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_left     (i_left),
        .i_right    (i_right),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_bclk     (o_bclk),
        .o_lrclk    (o_lrclk),
        .o_sdata    (o_sdata),
        .o_underrun (o_underrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected serial bit n edges after reset release.
    function automatic logic exp_sd(input int n);
        int f;
        int b;
        logic [15:0] w;
        f = n / 128;
        b = (n / 4) % 32;
        if (b == 0) begin
            if (f == 0) return 1'b0;
            w = frame_r[f-1];
            return w[0];
        end
        if (b <= 16) begin
            w = frame_l[f];
            return w[16-b];
        end
        w = frame_r[f];
        return w[32-b];
    endfunction

    function automatic logic exp_bclk(input int n);
        return (n % 4) >= 2;
    endfunction

    function automatic logic exp_lr(input int n);
        return ((n / 4) % 32) >= 16;
    endfunction

    task automatic test_reset();
        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_left  = '0;
        i_right = '0;
        repeat (3) @(negedge clk);
        i_rst = 1'b0;
        checks += 5;
        if (o_bclk !== 1'b0) begin
            errors++;
            $display("FAIL reset_bclk got %b want 0", o_bclk);
        end
        if (o_lrclk !== 1'b0) begin
            errors++;
            $display("FAIL reset_lrclk got %b want 0", o_lrclk);
        end
        if (o_sdata !== 1'b0) begin
            errors++;
            $display("FAIL reset_sdata got %b want 0", o_sdata);
        end
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready got %b want 1", o_ready);
        end
        if (o_underrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_underrun got %b want 0", o_underrun);
        end
    endtask

    // Frame 0: clocks, silence, no underrun; pair A5F0/0F0F enters holding.
    task automatic test_clocking();
        for (int n = 1; n <= 127; n++) begin
            @(negedge clk);
            checks += 4;
            if (o_bclk !== exp_bclk(n)) begin
                errors++;
                $display("FAIL clk_bclk n=%0d got %b want %b", n, o_bclk, exp_bclk(n));
            end
            if (o_lrclk !== exp_lr(n)) begin
                errors++;
                $display("FAIL clk_lrclk n=%0d got %b want %b", n, o_lrclk, exp_lr(n));
            end
            if (o_sdata !== 1'b0) begin
                errors++;
                $display("FAIL clk_sdata n=%0d got %b want 0", n, o_sdata);
            end
            if (o_underrun !== 1'b0) begin
                errors++;
                $display("FAIL clk_underrun n=%0d got %b want 0", n, o_underrun);
            end
            if (n == 20) begin
                checks++;
                if (o_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL clk_ready_pre got %b want 1", o_ready);
                end
                i_left  = 16'hA5F0;
                i_right = 16'h0F0F;
                i_valid = 1'b1;
            end
            if (n == 21) begin
                checks++;
                if (o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL clk_ready_post got %b want 0", o_ready);
                end
                i_valid = 1'b0;
            end
        end
    endtask

    // Frame 1 plays A5F0/0F0F; back-to-back stimulus begins here.
    task automatic test_single_pair();
        for (int n = 128; n <= 255; n++) begin
            @(negedge clk);
            checks += 2;
            if (o_sdata !== exp_sd(n)) begin
                errors++;
                $display("FAIL single_sdata n=%0d got %b want %b", n, o_sdata, exp_sd(n));
            end
            if (o_lrclk !== exp_lr(n)) begin
                errors++;
                $display("FAIL single_lrclk n=%0d got %b want %b", n, o_lrclk, exp_lr(n));
            end
            if (n == 128) begin
                checks += 2;
                if (o_underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL single_underrun got %b want 0", o_underrun);
                end
                if (o_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL single_ready got %b want 1", o_ready);
                end
            end
            if (n == 140) begin
                i_left  = 16'h1111;
                i_right = 16'h2222;
                i_valid = 1'b1;
            end
            if (n == 141) begin
                i_left  = 16'h3333;
                i_right = 16'h4444;
            end
            if (n == 141 || n == 255) begin
                checks++;
                if (o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_full n=%0d got %b want 0", n, o_ready);
                end
            end
        end
    endtask

    // Frames 2 and 3 carry 1111/2222 then 3333/4444.
    task automatic test_back_to_back();
        for (int n = 256; n <= 511; n++) begin
            @(negedge clk);
            checks++;
            if (o_sdata !== exp_sd(n)) begin
                errors++;
                $display("FAIL b2b_sdata n=%0d got %b want %b", n, o_sdata, exp_sd(n));
            end
            if (n == 256 || n == 384) begin
                checks += 2;
                if (o_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_rise n=%0d got %b want 1", n, o_ready);
                end
                if (o_underrun !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_underrun n=%0d got %b want 0", n, o_underrun);
                end
            end
            if (n == 257) begin
                checks++;
                if (o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_second_accept got %b want 0", o_ready);
                end
                i_valid = 1'b0;
            end
        end
    endtask

    // Frames 4 and 5 underrun; 7FFF/8000 resumes in frame 6.
    task automatic test_underrun();
        logic eu;
        for (int n = 512; n <= 895; n++) begin
            @(negedge clk);
            eu = (n == 512) || (n == 640);
            checks += 2;
            if (o_sdata !== exp_sd(n)) begin
                errors++;
                $display("FAIL urun_sdata n=%0d got %b want %b", n, o_sdata, exp_sd(n));
            end
            if (o_underrun !== eu) begin
                errors++;
                $display("FAIL urun_pulse n=%0d got %b want %b", n, o_underrun, eu);
            end
            if (n == 700) begin
                i_left  = 16'h7FFF;
                i_right = 16'h8000;
                i_valid = 1'b1;
            end
            if (n == 701) i_valid = 1'b0;
        end
    endtask

    // Pair arrives exactly on the frame-tick edge with holding empty.
    task automatic test_simultaneous();
        logic eu;
        for (int n = 896; n <= 1194; n++) begin
            @(negedge clk);
            eu = (n == 896) || (n == 1024);
            checks += 2;
            if (o_sdata !== exp_sd(n)) begin
                errors++;
                $display("FAIL simul_sdata n=%0d got %b want %b", n, o_sdata, exp_sd(n));
            end
            if (o_underrun !== eu) begin
                errors++;
                $display("FAIL simul_pulse n=%0d got %b want %b", n, o_underrun, eu);
            end
            if (n == 1023) begin
                i_left  = 16'h00FF;
                i_right = 16'hFF00;
                i_valid = 1'b1;
            end
            if (n == 1024) begin
                checks++;
                if (o_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL simul_accept got %b want 0", o_ready);
                end
                i_valid = 1'b0;
            end
            if (n == 1160) begin
                i_left  = 16'h1234;
                i_right = 16'h5678;
                i_valid = 1'b1;
            end
            if (n == 1161) i_valid = 1'b0;
        end
    endtask

    // Reset at bit 10 of frame 9 with 1234/5678 buffered.
    task automatic test_mid_reset();
        checks += 3;
        if (o_sdata !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_sdata got %b want 1", o_sdata);
        end
        if (o_bclk !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre_bclk got %b want 1", o_bclk);
        end
        if (o_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_pre_ready got %b want 0", o_ready);
        end
        #1 i_rst = 1'b1;
        #1;
        checks += 5;
        if (o_sdata !== 1'b0) begin
            errors++;
            $display("FAIL mid_sdata got %b want 0", o_sdata);
        end
        if (o_bclk !== 1'b0) begin
            errors++;
            $display("FAIL mid_bclk got %b want 0", o_bclk);
        end
        if (o_lrclk !== 1'b0) begin
            errors++;
            $display("FAIL mid_lrclk got %b want 0", o_lrclk);
        end
        if (o_underrun !== 1'b0) begin
            errors++;
            $display("FAIL mid_underrun got %b want 0", o_underrun);
        end
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_ready got %b want 1", o_ready);
        end
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        for (int n = 1; n <= 255; n++) begin
            @(negedge clk);
            checks += 3;
            if (o_sdata !== 1'b0) begin
                errors++;
                $display("FAIL post_sdata n=%0d got %b want 0", n, o_sdata);
            end
            if (o_underrun !== (n == 128)) begin
                errors++;
                $display("FAIL post_underrun n=%0d got %b want %b", n, o_underrun, n == 128);
            end
            if (o_bclk !== exp_bclk(n)) begin
                errors++;
                $display("FAIL post_bclk n=%0d got %b want %b", n, o_bclk, exp_bclk(n));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 12; i++) begin
            frame_l[i] = '0;
            frame_r[i] = '0;
        end
        frame_l[1] = 16'hA5F0;
        frame_r[1] = 16'h0F0F;
        frame_l[2] = 16'h1111;
        frame_r[2] = 16'h2222;
        frame_l[3] = 16'h3333;
        frame_r[3] = 16'h4444;
        frame_l[6] = 16'h7FFF;
        frame_r[6] = 16'h8000;
        frame_l[9] = 16'h00FF;
        frame_r[9] = 16'hFF00;
        test_reset();
        test_clocking();
        test_single_pair();
        test_back_to_back();
        test_underrun();
        test_simultaneous();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
